// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_arb_pkg
//  Purpose  : Shared types, limits and the round-robin pick helper for the
//             FIFO write-port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

  // Two-state arbiter: arbitrate (IDLE) or stream beats for one owner (XFER)
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Largest requester count the pick helper is written for
  localparam int C_MAX_REQ = 8;

  // Default limits and the minimum counter widths needed to hold them
  localparam int C_BURST_MAX       = 64;
  localparam int C_TIMEOUT         = 15;
  localparam int C_CNT_WIDTH_MIN   = $clog2(C_BURST_MAX + 1);
  localparam int C_TO_WIDTH_MIN    = $clog2(C_TIMEOUT + 1);

  // Index of the first set request bit scanning ptr+1, ptr+2, ... modulo n.
  // Returns 0 when no bit is set; callers gate on their own any flag.
  function automatic int rr_pick(input logic [C_MAX_REQ-1:0] req,
                                 input int ptr,
                                 input int n);
    int   idx;
    logic found;
    rr_pick = 0;
    found   = 1'b0;
    for (int k = 1; k <= C_MAX_REQ; k++) begin
      if (k <= n) begin
        idx = (ptr + k) % n;
        if (!found && req[idx[2:0]]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter_n
//  Purpose  : Combinational round-robin picker. Given a request vector and
//             the index of the last served requester, returns the winner as
//             one-hot and as an index, plus an any-request flag.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_n
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [N_REQ-1:0]    req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [N_REQ-1:0]    win_onehot,
  output logic [ID_WIDTH-1:0] win_idx,
  output logic                win_any
);

  logic [C_MAX_REQ-1:0] w_req_pad;

  // Pad the request vector to the helper width and pick the next winner
  always_comb begin
    w_req_pad              = '0;
    w_req_pad[N_REQ-1:0]   = req;
    win_idx                = ID_WIDTH'(rr_pick(w_req_pad, int'(ptr), N_REQ));
    win_any                = |req;
    win_onehot             = '0;
    if (win_any) begin
      win_onehot[win_idx]  = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Packet-locked round-robin arbiter sharing one FIFO write port
//             among N_REQ producers. An owner keeps the port until its LAST
//             beat, the burst cap, or an idle timeout (which pulses ABORT).
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 2,
  parameter int BURST_MAX  = 64,
  parameter int CNT_WIDTH  = 7,
  parameter int TIMEOUT    = 15,
  parameter int TO_WIDTH   = 4
) (
  input  logic                        CLK_WR,
  input  logic                        RST_WR,
  input  logic [N_REQ-1:0]            REQ,
  input  logic [N_REQ-1:0]            LAST,
  input  logic [N_REQ*DATA_WIDTH-1:0] DATA_IN,
  output logic [N_REQ-1:0]            GNT,
  input  logic                        FIFO_FULL,
  output logic                        FIFO_WR_EN,
  output logic [DATA_WIDTH-1:0]       FIFO_WR_DATA,
  output logic [ID_WIDTH-1:0]         OWNER_ID,
  output logic                        BUSY,
  output logic                        ABORT
);

  localparam logic [CNT_WIDTH-1:0] C_BEAT_LAST = CNT_WIDTH'(BURST_MAX - 1);
  localparam logic [TO_WIDTH-1:0]  C_TO_LAST   = TO_WIDTH'(TIMEOUT - 1);
  localparam logic [ID_WIDTH-1:0]  C_PTR_RST   = ID_WIDTH'(N_REQ - 1);

  arb_state_t              r_state,    w_state_nxt;
  logic [ID_WIDTH-1:0]     r_owner,    w_owner_nxt;
  logic [ID_WIDTH-1:0]     r_ptr,      w_ptr_nxt;
  logic [CNT_WIDTH-1:0]    r_beat_cnt, w_beat_nxt;
  logic [TO_WIDTH-1:0]     r_to_cnt,   w_to_nxt;
  logic                    r_abort,    w_abort_nxt;

  logic [N_REQ-1:0]        w_win_onehot;
  logic [ID_WIDTH-1:0]     w_win_idx;
  logic                    w_win_any;
  logic                    w_start;
  logic                    w_own_req;
  logic                    w_own_last;
  logic                    w_acc;
  logic [DATA_WIDTH-1:0]   w_slice [N_REQ];

  rr_arbiter_n #(
    .N_REQ    (N_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .req        (REQ),
    .ptr        (r_ptr),
    .win_onehot (w_win_onehot),
    .win_idx    (w_win_idx),
    .win_any    (w_win_any)
  );

  // Split the flat data bus into one word per requester
  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign w_slice[i] = DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // The winner must be a live requester before a grant is taken
  assign w_start      = w_win_any && ((w_win_onehot & REQ) != '0);
  assign w_own_req    = REQ[r_owner];
  assign w_own_last   = LAST[r_owner];
  assign FIFO_WR_DATA = w_slice[r_owner];
  assign OWNER_ID     = r_owner;
  assign BUSY         = (r_state == XFER);
  assign ABORT        = r_abort;

  // Next-state, counter updates and the zero-latency beat handshake
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_beat_nxt  = r_beat_cnt;
    w_to_nxt    = r_to_cnt;
    w_abort_nxt = 1'b0;
    w_acc       = 1'b0;
    GNT         = '0;
    FIFO_WR_EN  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = XFER;
          w_owner_nxt = w_win_idx;
          w_beat_nxt  = '0;
          w_to_nxt    = '0;
        end
      end
      XFER: begin
        w_acc        = w_own_req && !FIFO_FULL;
        FIFO_WR_EN   = w_acc;
        GNT[r_owner] = w_acc;
        // Backpressure (owner requesting, FIFO full) leaves to_cnt alone
        if (w_acc) begin
          w_to_nxt = '0;
          if (r_beat_cnt != '1) begin
            w_beat_nxt = r_beat_cnt + 1'b1;
          end
        end else if (!w_own_req && (r_to_cnt != '1)) begin
          w_to_nxt = r_to_cnt + 1'b1;
        end
        // LAST and the burst cap share one release path; ptr moves past owner
        if (w_acc && (w_own_last || (r_beat_cnt == C_BEAT_LAST))) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = r_owner;
        end else if (!w_own_req && (r_to_cnt == C_TO_LAST)) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = r_owner;
          w_abort_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and counter registers; reset drops any ownership at once
  always_ff @(posedge CLK_WR or negedge RST_WR) begin
    if (!RST_WR) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_ptr      <= C_PTR_RST;
      r_beat_cnt <= '0;
      r_to_cnt   <= '0;
      r_abort    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_ptr      <= w_ptr_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_to_cnt   <= w_to_nxt;
      r_abort    <= w_abort_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Purpose  : Directed self-checking bench for fifo_wr_arbiter (burst cap 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  logic        CLK_WR = 1'b0;
  logic        RST_WR;
  logic [3:0]  REQ;
  logic [3:0]  LAST;
  logic [63:0] DATA_IN;
  logic [3:0]  GNT;
  logic        FIFO_FULL;
  logic        FIFO_WR_EN;
  logic [15:0] FIFO_WR_DATA;
  logic [1:0]  OWNER_ID;
  logic        BUSY;
  logic        ABORT;

  logic [15:0] d [4];
  int          n_vec = 0;
  int          n_err = 0;
  int          pcnt [4];

  assign DATA_IN = {d[3], d[2], d[1], d[0]};

  always #5 CLK_WR = ~CLK_WR;

  fifo_wr_arbiter #(
    .N_REQ(4), .DATA_WIDTH(16), .ID_WIDTH(2), .BURST_MAX(4),
    .CNT_WIDTH(7), .TIMEOUT(15), .TO_WIDTH(4)
  ) dut (
    .CLK_WR(CLK_WR), .RST_WR(RST_WR), .REQ(REQ), .LAST(LAST),
    .DATA_IN(DATA_IN), .GNT(GNT), .FIFO_FULL(FIFO_FULL),
    .FIFO_WR_EN(FIFO_WR_EN), .FIFO_WR_DATA(FIFO_WR_DATA),
    .OWNER_ID(OWNER_ID), .BUSY(BUSY), .ABORT(ABORT)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int oh2i(input logic [3:0] v);
    oh2i = 0;
    for (int i = 0; i < 4; i++) if (v[i]) oh2i = i;
  endfunction

  logic [3:0] t2_gnt [15] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4,
                              4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1};
  logic [3:0] t4_gnt [12] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0,
                              4'h2, 4'h2, 4'h0, 4'h1, 4'h1, 4'h0};
  int         t4_len [4]  = '{6, 2, 0, 0};

  initial begin
    RST_WR = 1'b0; REQ = '0; LAST = '0; FIFO_FULL = 1'b0;
    d[0] = 16'h1234; d[1] = 16'h0A01; d[2] = 16'h2001; d[3] = 16'h3001;

    // Reset state
    @(negedge CLK_WR); #1;
    chk("rst_busy", BUSY, 0); chk("rst_gnt", GNT, 0); chk("rst_wren", FIFO_WR_EN, 0);
    chk("rst_owner", OWNER_ID, 0); chk("rst_abort", ABORT, 0);
    chk("rst_data", FIFO_WR_DATA, 16'h1234);
    @(negedge CLK_WR); RST_WR = 1'b1;

    // Single requester, three beats
    @(negedge CLK_WR); REQ = 4'b0010; #1;
    chk("t1_idle_gnt", GNT, 0); chk("t1_idle_busy", BUSY, 0);
    @(negedge CLK_WR); #1;
    chk("t1_b1_gnt", GNT, 4'b0010); chk("t1_b1_wren", FIFO_WR_EN, 1);
    chk("t1_b1_data", FIFO_WR_DATA, 16'h0A01); chk("t1_owner", OWNER_ID, 1);
    chk("t1_busy", BUSY, 1);
    @(negedge CLK_WR); d[1] = 16'h0A02; #1;
    chk("t1_b2_gnt", GNT, 4'b0010); chk("t1_b2_data", FIFO_WR_DATA, 16'h0A02);
    @(negedge CLK_WR); d[1] = 16'h0A03; LAST = 4'b0010; #1;
    chk("t1_b3_gnt", GNT, 4'b0010); chk("t1_b3_data", FIFO_WR_DATA, 16'h0A03);
    // ptr = 1: requesters 0 and 2 both ask, 2 must win, then 0
    @(negedge CLK_WR); REQ = 4'b0101; LAST = 4'b0101; #1;
    chk("t1_end_busy", BUSY, 0); chk("t1_end_gnt", GNT, 0);
    @(negedge CLK_WR); #1;
    chk("t1_ptr_owner", OWNER_ID, 2); chk("t1_ptr_gnt", GNT, 4'b0100);
    @(negedge CLK_WR); REQ = 4'b0001; LAST = 4'b0001; #1;
    chk("t1_next_idle", GNT, 0);
    @(negedge CLK_WR); #1;
    chk("t1_next_gnt", GNT, 4'b0001);
    @(negedge CLK_WR); REQ = '0; LAST = '0; RST_WR = 1'b0;
    @(negedge CLK_WR); RST_WR = 1'b1;

    // All four requesting, 2-beat packets, from ptr = 3
    for (int i = 0; i < 4; i++) pcnt[i] = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge CLK_WR);
      REQ = 4'b1111;
      for (int i = 0; i < 4; i++) begin
        LAST[i] = pcnt[i][0];
        d[i]    = {4'hD, 4'(i), 8'(pcnt[i])};
      end
      #1;
      chk($sformatf("t2_gnt_c%0d", c), GNT, t2_gnt[c]);
      if (t2_gnt[c] != 0) chk($sformatf("t2_data_c%0d", c), FIFO_WR_DATA, d[oh2i(t2_gnt[c])]);
      for (int i = 0; i < 4; i++) if (GNT[i]) pcnt[i]++;
    end
    @(negedge CLK_WR); REQ = '0; LAST = '0;

    // Backpressure on owner 2 for 20 cycles (ptr = 0)
    @(negedge CLK_WR); REQ = 4'b0100; d[2] = 16'h2001; #1;
    chk("t3_idle", GNT, 0);
    @(negedge CLK_WR); #1;
    chk("t3_b1_gnt", GNT, 4'b0100); chk("t3_b1_data", FIFO_WR_DATA, 16'h2001);
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK_WR); FIFO_FULL = 1'b1; d[2] = 16'h2002; #1;
      chk($sformatf("t3_full_gnt_c%0d", c), GNT, 0);
      chk($sformatf("t3_full_wren_c%0d", c), FIFO_WR_EN, 0);
      chk($sformatf("t3_full_abort_c%0d", c), ABORT, 0);
      chk($sformatf("t3_full_busy_c%0d", c), BUSY, 1);
    end
    @(negedge CLK_WR); FIFO_FULL = 1'b0; LAST = 4'b0100; #1;
    chk("t3_resume_gnt", GNT, 4'b0100); chk("t3_resume_data", FIFO_WR_DATA, 16'h2002);
    @(negedge CLK_WR); REQ = '0; LAST = '0; #1;
    chk("t3_end_busy", BUSY, 0); chk("t3_end_abort", ABORT, 0);

    // Burst cap 4: requester 0 sends 6 beats while 1 waits (ptr = 2)
    for (int i = 0; i < 4; i++) pcnt[i] = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK_WR);
      for (int i = 0; i < 4; i++) begin
        REQ[i]  = (pcnt[i] < t4_len[i]);
        LAST[i] = (pcnt[i] == t4_len[i] - 1);
        d[i]    = {4'hC, 4'(i), 8'(pcnt[i])};
      end
      #1;
      chk($sformatf("t4_gnt_c%0d", c), GNT, t4_gnt[c]);
      if (t4_gnt[c] != 0) chk($sformatf("t4_data_c%0d", c), FIFO_WR_DATA, d[oh2i(t4_gnt[c])]);
      for (int i = 0; i < 4; i++) if (GNT[i]) pcnt[i]++;
    end
    @(negedge CLK_WR); REQ = '0; LAST = '0;

    // Timeout: owner 3 stalls for 15 cycles, 0 and 2 waiting (ptr = 0)
    @(negedge CLK_WR); REQ = 4'b1000; #1;
    chk("t5_idle", GNT, 0);
    @(negedge CLK_WR); #1;
    chk("t5_b1_gnt", GNT, 4'b1000); chk("t5_owner", OWNER_ID, 3);
    for (int c = 0; c < 15; c++) begin
      @(negedge CLK_WR); REQ = 4'b0101; LAST = 4'b0101; #1;
      chk($sformatf("t5_stall_gnt_c%0d", c), GNT, 0);
      chk($sformatf("t5_stall_abort_c%0d", c), ABORT, 0);
      chk($sformatf("t5_stall_busy_c%0d", c), BUSY, 1);
    end
    @(negedge CLK_WR); #1;
    chk("t5_abort_hi", ABORT, 1); chk("t5_abort_busy", BUSY, 0); chk("t5_abort_gnt", GNT, 0);
    @(negedge CLK_WR); #1;
    chk("t5_abort_lo", ABORT, 0); chk("t5_next_owner", OWNER_ID, 0);
    chk("t5_next_gnt", GNT, 4'b0001);
    @(negedge CLK_WR); REQ = 4'b0100; LAST = 4'b0100; #1;
    chk("t5_idle2", GNT, 0);
    @(negedge CLK_WR); #1;
    chk("t5_gnt2", GNT, 4'b0100);
    @(negedge CLK_WR); REQ = '0; LAST = '0;

    // Async reset in the middle of owner 1's packet (ptr = 2)
    d[0] = 16'h5A5A;
    @(negedge CLK_WR); REQ = 4'b0010; #1;
    chk("t6_idle", GNT, 0);
    @(negedge CLK_WR); #1;
    chk("t6_b1_gnt", GNT, 4'b0010); chk("t6_b1_busy", BUSY, 1);
    @(negedge CLK_WR); RST_WR = 1'b0; REQ = 4'b1100; #1;
    chk("t6_rst_busy", BUSY, 0); chk("t6_rst_gnt", GNT, 0); chk("t6_rst_wren", FIFO_WR_EN, 0);
    chk("t6_rst_owner", OWNER_ID, 0); chk("t6_rst_data", FIFO_WR_DATA, 16'h5A5A);
    @(negedge CLK_WR); RST_WR = 1'b1; #1;
    chk("t6_rel_gnt", GNT, 0);
    @(negedge CLK_WR); LAST = 4'b1100; #1;
    chk("t6_first_owner", OWNER_ID, 2); chk("t6_first_gnt", GNT, 4'b0100);
    @(negedge CLK_WR); REQ = '0; LAST = '0;
    @(negedge CLK_WR);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
